// File: rtl/rans_pkg.sv
// Shared constants, FSM encoding and the symbol-legality check for the N-lane rANS encoder.
package rans_pkg;
  localparam logic [31:0] RANS_L       = 32'h0001_0000;
  localparam int          RANS_WORD_W  = 16;
  localparam int          RANS_STATE_W = 32;

  typedef enum logic [2:0] {IDLE, RENORM, DIV, UPDATE, FLUSH} enc_state_t;

  // A zero-width interval or one running past M cannot be coded.
  function automatic logic freq_bad(input logic [15:0] start, input logic [15:0] freq,
                                    input int unsigned pbits);
    logic [16:0] sum;
    sum = {1'b0, start} + {1'b0, freq};
    return (freq == 16'd0) || (sum > (17'd1 << pbits));
  endfunction
endpackage

// File: rtl/rans_div.sv
// 32/16 restoring divider, one quotient bit per cycle; done pulses on the 32nd iteration.
module rans_div (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] dividend_i,
  input  logic [15:0] divisor_i,
  output logic        busy,
  output logic        done,
  output logic [31:0] q,
  output logic [15:0] r
);
  logic        busy_q;
  logic [4:0]  cnt_q;
  logic [31:0] quo_q;
  logic [15:0] rem_q, d_q;
  logic [16:0] trial;
  logic        ge;

  // rem < divisor always holds, so the shifted trial value fits in 17 bits.
  assign trial = {rem_q, quo_q[31]};
  assign ge    = trial >= {1'b0, d_q};
  assign busy  = busy_q;
  assign done  = busy_q && (cnt_q == 5'd31);
  assign q     = quo_q;
  assign r     = rem_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      d_q    <= '0;
    end else if (start && !busy_q) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      quo_q  <= dividend_i;
      rem_q  <= '0;
      d_q    <= divisor_i;
    end else if (busy_q) begin
      rem_q  <= ge ? 16'(trial - {1'b0, d_q}) : trial[15:0];
      quo_q  <= {quo_q[30:0], ge};
      cnt_q  <= cnt_q + 5'd1;
      if (cnt_q == 5'd31) busy_q <= 1'b0;
    end
  end
endmodule

// File: rtl/rans_encoder_nlane.sv
// N-lane interleaved rANS encoder: round-robin lane assignment, 16-bit renorm words,
// per-lane state flush on tlast.
module rans_encoder_nlane
  import rans_pkg::*;
#(
  parameter int LANES     = 4,
  parameter int PROB_BITS = 12,
  parameter int LANE_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  output logic [15:0]       m_axis_tdata,
  output logic [LANE_W-1:0] m_axis_tuser,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  output logic              err_freq
);
  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int NX    = 1 << IDX_W;

  enc_state_t        state_q;
  logic [31:0]       x_q [NX];
  logic [LANE_W-1:0] ptr_q, lane_q, fidx_q, fnext;
  logic [15:0]       start_q, freq_q;
  logic              last_q, fhalf_q, err_q, s_tready_q;
  logic [15:0]       m_tdata_q;
  logic [LANE_W-1:0] m_tuser_q;
  logic              m_tvalid_q, m_tlast_q;

  logic [15:0] start_in, freq_in;
  logic [31:0] x_ptr, x_lane, fx, fx_next, x_upd, div_dividend;
  logic [32:0] xmax_in;
  logic        emit_in, bad_in, go, div_start, div_busy, div_done;
  logic [31:0] div_q;
  logic [15:0] div_r;

  assign start_in = s_axis_tdata[31:16];
  assign freq_in  = s_axis_tdata[15:0];
  assign bad_in   = freq_bad(start_in, freq_in, PROB_BITS);
  assign x_ptr    = x_q[ptr_q[IDX_W-1:0]];
  assign x_lane   = x_q[lane_q[IDX_W-1:0]];
  assign fnext    = fidx_q + 1'b1;
  assign fx       = x_q[fidx_q[IDX_W-1:0]];
  assign fx_next  = x_q[fnext[IDX_W-1:0]];

  // Renorm decision is made at accept time so the word is already valid on entering RENORM.
  assign xmax_in  = 33'(freq_in) << (32 - PROB_BITS);
  assign emit_in  = {1'b0, x_ptr} >= xmax_in;

  assign go           = (!m_tvalid_q || m_axis_tready) && !div_busy;
  assign div_start    = (state_q == RENORM) && go;
  assign div_dividend = m_tvalid_q ? {16'h0, x_lane[31:16]} : x_lane;
  assign x_upd        = (div_q << PROB_BITS) + {16'h0, div_r} + {16'h0, start_q};

  rans_div u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (div_start),
    .dividend_i (div_dividend),
    .divisor_i  (freq_q),
    .busy       (div_busy),
    .done       (div_done),
    .q          (div_q),
    .r          (div_r)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      for (int k = 0; k < NX; k++) x_q[k] <= RANS_L;
      ptr_q      <= '0;
      lane_q     <= '0;
      fidx_q     <= '0;
      fhalf_q    <= 1'b0;
      start_q    <= '0;
      freq_q     <= '0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
      s_tready_q <= 1'b0;
      m_tdata_q  <= '0;
      m_tuser_q  <= '0;
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!s_tready_q) begin
            s_tready_q <= 1'b1;
          end else if (s_axis_tvalid) begin
            start_q <= start_in;
            freq_q  <= freq_in;
            last_q  <= s_axis_tlast;
            lane_q  <= ptr_q;
            if (bad_in) begin
              err_q      <= 1'b1;
              s_tready_q <= !s_axis_tlast;
              if (s_axis_tlast) begin
                state_q <= FLUSH;
                fidx_q  <= '0;
                fhalf_q <= 1'b0;
              end
            end else begin
              s_tready_q <= 1'b0;
              state_q    <= RENORM;
              if (emit_in) begin
                m_tvalid_q <= 1'b1;
                m_tdata_q  <= x_ptr[15:0];
                m_tuser_q  <= ptr_q;
                m_tlast_q  <= 1'b0;
              end
            end
          end
        end
        RENORM: begin
          if (go) begin
            if (m_tvalid_q) begin
              x_q[lane_q[IDX_W-1:0]] <= {16'h0, x_lane[31:16]};
              m_tvalid_q <= 1'b0;
            end
            state_q <= DIV;
          end
        end
        DIV: begin
          if (div_done) state_q <= UPDATE;
        end
        UPDATE: begin
          x_q[lane_q[IDX_W-1:0]] <= x_upd;
          ptr_q <= (ptr_q == LANE_W'(LANES - 1)) ? '0 : ptr_q + 1'b1;
          if (last_q) begin
            state_q <= FLUSH;
            fidx_q  <= '0;
            fhalf_q <= 1'b0;
          end else begin
            state_q    <= IDLE;
            s_tready_q <= 1'b1;
          end
        end
        FLUSH: begin
          if (!m_tvalid_q) begin
            m_tvalid_q <= 1'b1;
            m_tdata_q  <= fx[15:0];
            m_tuser_q  <= fidx_q;
            m_tlast_q  <= 1'b0;
          end else if (m_axis_tready) begin
            if (m_tlast_q) begin
              for (int k = 0; k < NX; k++) x_q[k] <= RANS_L;
              ptr_q      <= '0;
              m_tvalid_q <= 1'b0;
              m_tlast_q  <= 1'b0;
              state_q    <= IDLE;
              s_tready_q <= 1'b1;
            end else if (!fhalf_q) begin
              fhalf_q   <= 1'b1;
              m_tdata_q <= fx[31:16];
              m_tlast_q <= (fidx_q == LANE_W'(LANES - 1));
            end else begin
              fhalf_q   <= 1'b0;
              fidx_q    <= fnext;
              m_tdata_q <= fx_next[15:0];
              m_tuser_q <= fnext;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_axis_tready = s_tready_q;
  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tuser  = m_tuser_q;
  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tlast  = m_tlast_q;
  assign err_freq      = err_q;
endmodule
